chimp_sequence_checker: RTL and testbench

- Game-logic stage directly downstream of the chimp-test click-to-cell mapper, which supplies registered BoxX/BoxY (0..7).
- Holds the current round's layout: which grid cell carries each number 1..N.
- Checks the player's clicks against the required ascending order and hides the numbers after the first correct click.
- Tracks strikes and level, and requests new layouts from the layout generator.

---
 rtl/chimp_pkg.sv | 34 +++
 rtl/chimp_layout_table.sv | 65 ++++++
 rtl/chimp_sequence_checker.sv | 180 ++++++++++++++++++
 tb/tb_chimp_sequence_checker.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chimp_pkg.sv
// rtl/chimp_pkg.sv - shared types and constants for the chimp-test game logic
package chimp_pkg;

  localparam int GRID_DIM    = 8;
  localparam int MAX_NUMS    = 16;
  localparam int MIN_NUMS    = 4;
  localparam int MAX_STRIKES = 3;

  localparam int COORD_W = $clog2(GRID_DIM);
  localparam int IDX_W   = $clog2(MAX_NUMS);
  localparam int CNT_W   = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHOW,
    PLAY,
    PASS,
    FAIL,
    OVER
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cell_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input int unsigned      lim);
    if (v >= CNT_W'(lim)) return CNT_W'(lim);
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/chimp_layout_table.sv
// rtl/chimp_layout_table.sv - layout register file, visibility mask and lowest-index hit search
module chimp_layout_table
  import chimp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  cell_t               wr_cell,
  input  logic                clr_one,
  input  logic [IDX_W-1:0]    clr_idx,
  input  logic                clr_all,
  input  logic [CNT_W-1:0]    active_cnt,
  input  cell_t               probe,
  input  logic [IDX_W-1:0]    rd_idx,
  output cell_t               rd_cell,
  output logic [MAX_NUMS-1:0] mask,
  output logic                hit,
  output logic [IDX_W-1:0]    hit_idx
);

  cell_t               table_q [MAX_NUMS];
  logic [MAX_NUMS-1:0] match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_NUMS; i++) table_q[i] <= '0;
    end else if (wr_en) begin
      table_q[wr_idx] <= wr_cell;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (clr_all) begin
      mask <= '0;
    end else begin
      if (wr_en)   mask[wr_idx]  <= 1'b1;
      if (clr_one) mask[clr_idx] <= 1'b0;
    end
  end

  // Entries beyond the round's count may hold stale cells from a longer round.
  always_comb begin
    match = '0;
    for (int i = 0; i < MAX_NUMS; i++) begin
      match[i] = mask[i] && (table_q[i] == probe) && (CNT_W'(i) < active_cnt);
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = MAX_NUMS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign rd_cell = table_q[rd_idx];

endmodule

// File: rtl/chimp_sequence_checker.sv
// rtl/chimp_sequence_checker.sv - chimp-test round control: click ordering, strikes and level
module chimp_sequence_checker
  import chimp_pkg::*;
(
  input  logic                clk,
  input  logic                iReset,
  input  logic                start,
  input  logic                click_in,
  input  logic [2:0]          BoxX,
  input  logic [2:0]          BoxY,
  input  logic                load_we,
  input  logic [3:0]          load_idx,
  input  logic [2:0]          load_x,
  input  logic [2:0]          load_y,
  input  logic                load_done,
  input  logic [3:0]          rd_idx,
  output logic [2:0]          rd_x,
  output logic [2:0]          rd_y,
  output logic [MAX_NUMS-1:0] visible_mask,
  output logic                hide_numbers,
  output logic [4:0]          num_count,
  output logic [3:0]          next_idx,
  output logic [1:0]          strikes,
  output logic                layout_req,
  output logic                round_pass,
  output logic                round_fail,
  output logic                game_over
);

  state_t     state, state_nxt;
  logic       click_d;
  logic [4:0] num_nxt;
  logic [3:0] next_nxt;
  logic [1:0] strikes_nxt;
  logic [1:0] strikes_inc;
  logic       hide_nxt;
  logic       tbl_we, clr_one, clr_all;
  logic       hit;
  logic [3:0] hit_idx;
  logic       click_hit;
  cell_t      wr_cell, probe, rd_cell;

  assign wr_cell     = '{x: load_x, y: load_y};
  assign probe       = '{x: BoxX, y: BoxY};
  assign rd_x        = rd_cell.x;
  assign rd_y        = rd_cell.y;
  assign click_hit   = click_d && hit;
  assign strikes_inc = strikes + 2'd1;

  chimp_layout_table u_table (
    .clk        (clk),
    .rst_n      (iReset),
    .wr_en      (tbl_we),
    .wr_idx     (load_idx),
    .wr_cell    (wr_cell),
    .clr_one    (clr_one),
    .clr_idx    (hit_idx),
    .clr_all    (clr_all),
    .active_cnt (num_count),
    .probe      (probe),
    .rd_idx     (rd_idx),
    .rd_cell    (rd_cell),
    .mask       (visible_mask),
    .hit        (hit),
    .hit_idx    (hit_idx)
  );

  // The mapper's BoxX/BoxY lag the press by one cycle, so the press is delayed to match.
  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      state        <= IDLE;
      click_d      <= 1'b0;
      num_count    <= 5'(MIN_NUMS);
      next_idx     <= '0;
      strikes      <= '0;
      hide_numbers <= 1'b0;
    end else begin
      state        <= state_nxt;
      click_d      <= click_in;
      num_count    <= num_nxt;
      next_idx     <= next_nxt;
      strikes      <= strikes_nxt;
      hide_numbers <= hide_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    num_nxt     = num_count;
    next_nxt    = next_idx;
    strikes_nxt = strikes;
    hide_nxt    = hide_numbers;
    tbl_we      = 1'b0;
    clr_one     = 1'b0;
    clr_all     = 1'b0;
    layout_req  = 1'b0;
    round_pass  = 1'b0;
    round_fail  = 1'b0;
    game_over   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          layout_req = 1'b1;
          state_nxt  = LOAD;
        end
      end

      LOAD: begin
        tbl_we = load_we && ({1'b0, load_idx} < num_count);
        if (load_done) begin
          hide_nxt  = 1'b0;
          next_nxt  = '0;
          state_nxt = SHOW;
        end
      end

      SHOW: begin
        if (click_hit) begin
          if (hit_idx == '0) begin
            clr_one   = 1'b1;
            hide_nxt  = 1'b1;
            next_nxt  = 4'd1;
            state_nxt = PLAY;
          end else begin
            state_nxt = FAIL;
          end
        end
      end

      PLAY: begin
        if (click_hit) begin
          if (hit_idx == next_idx) begin
            clr_one  = 1'b1;
            next_nxt = next_idx + 4'd1;
            if ({1'b0, next_idx} == num_count - 5'd1) state_nxt = PASS;
          end else begin
            state_nxt = FAIL;
          end
        end
      end

      PASS: begin
        round_pass = 1'b1;
        layout_req = 1'b1;
        num_nxt    = sat_inc(num_count, MAX_NUMS);
        clr_all    = 1'b1;
        hide_nxt   = 1'b0;
        state_nxt  = LOAD;
      end

      FAIL: begin
        round_fail  = 1'b1;
        strikes_nxt = strikes_inc;
        clr_all     = 1'b1;
        hide_nxt    = 1'b0;
        if (strikes_inc == 2'(MAX_STRIKES)) begin
          state_nxt = OVER;
        end else begin
          layout_req = 1'b1;
          state_nxt  = LOAD;
        end
      end

      OVER: begin
        game_over = 1'b1;
        if (start) begin
          num_nxt     = 5'(MIN_NUMS);
          strikes_nxt = '0;
          next_nxt    = '0;
          layout_req  = 1'b1;
          state_nxt   = LOAD;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_chimp_sequence_checker.sv
// tb/tb_chimp_sequence_checker.sv - self-checking bench for chimp_sequence_checker
module tb_chimp_sequence_checker;

  logic        clk = 1'b0;
  logic        iReset = 1'b0;
  logic        start = 1'b0, click_in = 1'b0, load_we = 1'b0, load_done = 1'b0;
  logic [2:0]  BoxX = '0, BoxY = '0, load_x = '0, load_y = '0;
  logic [3:0]  load_idx = '0, rd_idx = '0;
  logic [2:0]  rd_x, rd_y;
  logic [15:0] visible_mask;
  logic        hide_numbers;
  logic [4:0]  num_count;
  logic [3:0]  next_idx;
  logic [1:0]  strikes;
  logic        layout_req, round_pass, round_fail, game_over;

  int tests_run = 0;
  int tests_failed = 0;
  bit cmp_en = 1'b0;
  int lx[16], ly[16];

  chimp_sequence_checker dut (
    .clk          (clk),
    .iReset       (iReset),
    .start        (start),
    .click_in     (click_in),
    .BoxX         (BoxX),
    .BoxY         (BoxY),
    .load_we      (load_we),
    .load_idx     (load_idx),
    .load_x       (load_x),
    .load_y       (load_y),
    .load_done    (load_done),
    .rd_idx       (rd_idx),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .visible_mask (visible_mask),
    .hide_numbers (hide_numbers),
    .num_count    (num_count),
    .next_idx     (next_idx),
    .strikes      (strikes),
    .layout_req   (layout_req),
    .round_pass   (round_pass),
    .round_fail   (round_fail),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    tests_run++;
    if (act != exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Game model: a phase name plus the round's bookkeeping, advanced once per clock.
  string m_phase;
  int    m_tx[16], m_ty[16];
  bit    m_vis[16];
  bit    m_hide, m_click_d;
  int    m_num, m_next, m_strikes;

  task automatic model_reset();
    m_phase = "idle";
    for (int i = 0; i < 16; i++) begin
      m_tx[i] = 0; m_ty[i] = 0; m_vis[i] = 1'b0;
    end
    m_hide = 1'b0; m_click_d = 1'b0;
    m_num = 4; m_next = 0; m_strikes = 0;
  endtask

  task automatic model_clear_board();
    for (int i = 0; i < 16; i++) m_vis[i] = 1'b0;
    m_hide = 1'b0;
  endtask

  task automatic model_tick();
    bit pressed;
    int found;
    pressed   = m_click_d;
    m_click_d = click_in;
    found = -1;
    for (int i = 0; i < m_num && found < 0; i++)
      if (m_vis[i] && m_tx[i] == int'(BoxX) && m_ty[i] == int'(BoxY)) found = i;
    if (!pressed) found = -1;

    if (m_phase == "idle") begin
      if (start) m_phase = "load";
    end else if (m_phase == "load") begin
      if (load_we && int'(load_idx) < m_num) begin
        m_tx[load_idx] = int'(load_x);
        m_ty[load_idx] = int'(load_y);
        m_vis[load_idx] = 1'b1;
      end
      if (load_done) begin
        m_phase = "show"; m_hide = 1'b0; m_next = 0;
      end
    end else if (m_phase == "show") begin
      if (found == 0) begin
        m_vis[0] = 1'b0; m_hide = 1'b1; m_next = 1; m_phase = "play";
      end else if (found > 0) begin
        m_phase = "fail";
      end
    end else if (m_phase == "play") begin
      if (found == m_next) begin
        m_vis[found] = 1'b0;
        if (m_next == m_num - 1) m_phase = "pass";
        m_next = (m_next + 1) % 16;
      end else if (found >= 0) begin
        m_phase = "fail";
      end
    end else if (m_phase == "pass") begin
      m_num = (m_num < 16) ? m_num + 1 : 16;
      model_clear_board();
      m_phase = "load";
    end else if (m_phase == "fail") begin
      m_strikes++;
      model_clear_board();
      m_phase = (m_strikes == 3) ? "over" : "load";
    end else if (m_phase == "over") begin
      if (start) begin
        m_num = 4; m_strikes = 0; m_next = 0; m_phase = "load";
      end
    end
  endtask

  task automatic compare_all();
    int em;
    bit elr;
    em = 0;
    for (int i = 0; i < 16; i++) if (m_vis[i]) em |= (1 << i);
    elr = ((m_phase == "idle" || m_phase == "over") && start) || (m_phase == "pass") ||
          (m_phase == "fail" && m_strikes + 1 < 3);
    check("rd_x",         int'(rd_x),         m_tx[rd_idx]);
    check("rd_y",         int'(rd_y),         m_ty[rd_idx]);
    check("visible_mask", int'(visible_mask), em);
    check("hide_numbers", int'(hide_numbers), int'(m_hide));
    check("num_count",    int'(num_count),    m_num);
    check("next_idx",     int'(next_idx),     m_next);
    check("strikes",      int'(strikes),      m_strikes);
    check("layout_req",   int'(layout_req),   int'(elr));
    check("round_pass",   int'(round_pass),   int'(m_phase == "pass"));
    check("round_fail",   int'(round_fail),   int'(m_phase == "fail"));
    check("game_over",    int'(game_over),    int'(m_phase == "over"));
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge iReset);
      if (!iReset) model_reset();
      else model_tick();
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) compare_all();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    rd_idx = rd_idx + 4'd1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    #1;
    check("layout_req_on_start", int'(layout_req), 1);
    cyc();
    start = 1'b0;
  endtask

  task automatic load_layout(input int n);
    for (int i = 0; i < n; i++) begin
      load_we   = 1'b1;
      load_idx  = 4'(i);
      load_x    = 3'(lx[i]);
      load_y    = 3'(ly[i]);
      load_done = (i == n - 1);
      cyc();
    end
    load_we   = 1'b0;
    load_done = 1'b0;
  endtask

  // Returns two cycles after the press, when the round pulses are visible.
  task automatic do_click(input int x, input int y);
    click_in = 1'b1;
    cyc();
    click_in = 1'b0;
    BoxX = 3'(x);
    BoxY = 3'(y);
    cyc();
  endtask

  initial begin
    int n;
    lx[0] = 1; ly[0] = 1;
    lx[1] = 5; ly[1] = 2;
    lx[2] = 0; ly[2] = 7;
    lx[3] = 3; ly[3] = 3;
    lx[4] = 6; ly[4] = 6;

    cyc();
    cmp_en = 1'b1;
    cyc();
    check("reset_num_count", int'(num_count), 4);
    check("reset_game_over", int'(game_over), 0);
    check("reset_mask",      int'(visible_mask), 0);
    iReset = 1'b1;
    cyc();

    // Basic passing round, with an out-of-range write that must be dropped.
    pulse_start();
    load_we = 1'b1; load_idx = 4'd4; load_x = 3'd6; load_y = 3'd6;
    cyc();
    load_we = 1'b0;
    check("oob_write_mask", int'(visible_mask), 0);
    load_layout(4);
    check("loaded_mask", int'(visible_mask), 'hF);
    check("shown_hide", int'(hide_numbers), 0);
    do_click(1, 1);
    check("hide_after_first", int'(hide_numbers), 1);
    check("next_after_first", int'(next_idx), 1);
    do_click(5, 2);
    do_click(0, 7);
    do_click(3, 3);
    check("round_pass_pulse", int'(round_pass), 1);
    check("pass_layout_req", int'(layout_req), 1);
    cyc();
    check("num_after_pass", int'(num_count), 5);

    // Clicks on an empty cell and a cleared cell do nothing.
    load_layout(5);
    do_click(1, 1);
    do_click(5, 2);
    check("next_before_misses", int'(next_idx), 2);
    do_click(7, 7);
    check("empty_no_fail", int'(round_fail), 0);
    do_click(1, 1);
    check("cleared_no_fail", int'(round_fail), 0);
    check("next_after_misses", int'(next_idx), 2);
    check("mask_after_misses", int'(visible_mask), 'h1C);

    // Reset in PLAY with a press in flight.
    click_in = 1'b1;
    cyc();
    iReset = 1'b0;
    #1;
    check("midreset_num", int'(num_count), 4);
    check("midreset_next", int'(next_idx), 0);
    check("midreset_hide", int'(hide_numbers), 0);
    cyc();
    click_in = 1'b0;
    iReset = 1'b1;
    cyc();

    // Three failed rounds end the game.
    pulse_start();
    load_layout(4);
    do_click(5, 2);
    check("fail1_pulse", int'(round_fail), 1);
    check("fail1_layout_req", int'(layout_req), 1);
    cyc();
    check("fail1_strikes", int'(strikes), 1);
    check("fail1_num", int'(num_count), 4);
    load_layout(4);
    do_click(5, 2);
    cyc();
    check("fail2_strikes", int'(strikes), 2);
    load_layout(4);
    do_click(0, 7);
    check("fail3_pulse", int'(round_fail), 1);
    check("fail3_no_layout_req", int'(layout_req), 0);
    cyc();
    check("over_game_over", int'(game_over), 1);
    check("over_strikes", int'(strikes), 3);
    do_click(1, 1);
    check("over_click_ignored", int'(round_fail), 0);
    pulse_start();
    check("restart_strikes", int'(strikes), 0);
    check("restart_game_over", int'(game_over), 0);

    // Climb to the top level; the last round runs at full depth.
    for (int r = 0; r < 13; r++) begin
      n = (4 + r < 16) ? 4 + r : 16;
      for (int i = 0; i < 16; i++) begin
        lx[i] = i % 8; ly[i] = i / 8;
      end
      load_layout(n);
      if (n == 16) begin
        check("full_mask", int'(visible_mask), 'hFFFF);
        load_we = 1'b1; load_idx = 4'd0; load_x = 3'd7; load_y = 3'd7;
        cyc();
        load_we = 1'b0;
        rd_idx = 4'd0;
        #1;
        check("show_write_ignored_x", int'(rd_x), 0);
        check("show_write_ignored_y", int'(rd_y), 0);
      end
      for (int i = 0; i < n; i++) do_click(lx[i], ly[i]);
      check("climb_pass", int'(round_pass), 1);
      cyc();
      check("climb_num", int'(num_count), (5 + r < 16) ? 5 + r : 16);
    end

    cyc();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
